if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage controller. It owns the program counter, issues single-outstanding requests to a variable-latency instruction memory, and presents the fetched instruction and PC+4 to the IF/ID pipeline register. It honours the hazard unit's `stall` and the EX-stage `redirect`. When no valid instruction is available it drives a NOP (all zeros), so the IF/ID register inserts a bubble.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.

Ports:
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset (asserted at 0)
- `imem_req`  output  1  fetch request, one-cycle pulse; memory always accepts it
- `imem_addr`  output  32  fetch address, equal to the PC register
- `imem_rvalid`  input  1  response valid; at least 1 cycle after `imem_req`
- `imem_rdata`  input  32  instruction word, qualified by `imem_rvalid`
- `stall`  input  1  IF/ID hold from the hazard unit
- `redirect`  input  1  branch or jump taken; replace the PC
- `redirect_pc`  input  32  target address; bits [1:0] are ignored and forced to 00
- `if_instr`  output  32  instruction presented to IF/ID; 0 when `if_valid`=0
- `if_pc4`  output  32  address of `if_instr` plus 4; 0 when `if_valid`=0
- `if_valid`  output  1  `if_instr` and `if_pc4` hold a real fetched instruction

## Operation
- Registers: `pc` (32 bits), `state` (2 bits), and `if_instr`, `if_pc4`, `if_valid`, all registered.
- `imem_req` = (`state`==REQ) && !`redirect` && `reset`. `imem_addr` = `pc`.
- At most one request is outstanding at any time.
- State REQ, the reset state:
  - `redirect`: `pc` ← `redirect_pc`; stay in REQ; no request is issued.
  - Otherwise: the request is issued; go to WAIT.
- State WAIT:
  - `redirect`: `pc` ← `redirect_pc`. If `imem_rvalid` is high in the same cycle, drop the data and go to REQ; otherwise go to DROP.
  - `imem_rvalid` without `redirect`: `if_instr` ← `imem_rdata`, `if_pc4` ← `pc`+4, `if_valid` ← 1; go to HOLD.
  - `stall` has no effect in WAIT.
- State HOLD:
  - `redirect`: `pc` ← `redirect_pc`; clear the outputs; go to REQ.
  - `stall`=1: hold all outputs.
  - `stall`=0: IF/ID captures the outputs at this edge. Then `pc` ← `pc`+4, `if_instr` ← 0, `if_pc4` ← 0, `if_valid` ← 0; go to REQ.
- State DROP (one stale response pending):
  - `imem_rvalid`: discard the data; go to REQ.
  - `redirect`: `pc` ← `redirect_pc`; stay in DROP, or go to REQ if `imem_rvalid` is also high.
- "Clear the outputs" means `if_instr`=0, `if_pc4`=0, `if_valid`=0.
- Priority: `redirect` > `imem_rvalid` > `stall`.
- `imem_rvalid` is ignored in REQ and HOLD.
- Arithmetic: `pc`+4 and `if_pc4` wrap modulo 2^32, so 32'hFFFF_FFFC+4 = 32'h0000_0000.

## Timing
- Reset asserted: `state`=REQ, `pc`=`RESET_PC`, `if_instr`=0, `if_pc4`=0, `if_valid`=0, `imem_req`=0.
- Reset asserted mid-operation aborts any pending fetch immediately. The instruction memory shares the same reset, so no response arrives after reset release for a request issued before it.
- First `imem_req` is in the first cycle after reset deasserts.
- Fetch latency: request at cycle t, `imem_rvalid` at t+L (L≥1), `if_valid`=1 from t+L+1.
- Without stalls, the next request is issued 1 cycle after the edge that consumes the instruction.
- Best-case throughput is 1 instruction per 3 cycles with L=1. Bubble cycles present NOP, which is the intended behaviour.
- `redirect` takes effect at the next edge. The first request to the target is issued no earlier than the cycle after that edge, or after the stale response has been drained.

## Test plan
- Reset release with `RESET_PC`=0x100 and L=1: `imem_req` with addr 0x100 in cycle 1; then `if_valid`=1, `if_instr`=rdata, `if_pc4`=0x104; next request addr 0x104.
- `stall` held 3 cycles in HOLD: outputs stable and no `imem_req`. On release, outputs go to 0 and the request for pc+4 follows one cycle later.
- `redirect` to 0x2000 while in WAIT with L=4: the response at t+4 is discarded and `if_valid` stays 0. Next `imem_req` addr is 0x2000, and the instruction then appears with `if_pc4`=0x2004.
- `redirect` in the same cycle as `imem_rvalid`, and separately `redirect`+`stall` in HOLD: data is dropped, the state goes to REQ, `pc`=target, and `stall` is ignored.
- `pc`=0xFFFF_FFFC fetched and consumed: `if_pc4`=0x0000_0000, next `imem_addr`=0x0; `redirect_pc`=0x1003 yields `imem_addr`=0x1000.
- Reset pulsed low while in DROP: outputs are 0 and `pc`=`RESET_PC` immediately, and the fetch restarts cleanly after release.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage controller: owns the PC, issues single-outstanding
// fetches to a variable-latency memory and presents instr / PC+4 to IF/ID.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic [1:0]  dbg_state
);

  // Memory handshake: imem_req is a one-cycle pulse the memory always accepts;
  // exactly one imem_rvalid pulse answers each request, at least one cycle later.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] target;

  assign target = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:  if (!redirect) state_d = S_WAIT;
      S_WAIT: begin
        if (redirect)         state_d = imem_rvalid ? S_REQ : S_DROP;
        else if (imem_rvalid) state_d = S_HOLD;
      end
      S_HOLD: if (redirect || !stall) state_d = S_REQ;
      S_DROP: if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (redirect) pc_d = target;
    case (state_q)
      S_WAIT: begin
        if (!redirect && imem_rvalid) begin
          instr_d = imem_rdata;
          pc4_d   = pc_q + 32'd4;
          valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        // Leaving HOLD either way presents a bubble; only a consume advances the PC.
        if (redirect || !stall) begin
          instr_d = 32'h0;
          pc4_d   = 32'h0;
          valid_d = 1'b0;
        end
        if (!redirect && !stall) pc_d = pc_q + 32'd4;
      end
      default: ;
    endcase
  end

  assign imem_req  = (state_q == S_REQ) && !redirect && reset;
  assign imem_addr = pc_q;
  assign if_instr  = instr_q;
  assign if_pc4    = pc4_q;
  assign if_valid  = valid_q;
  assign dbg_state = state_q;

endmodule
